// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel/line counters with registered HS, VS, blank and start pulses.
// Decodes are taken from next-state counter values, so every output lines up with the counters.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = 11
) (
  input  logic          pixel_clk,
  input  logic          rst_n,
  input  logic          en,
  output logic          HS,
  output logic          VS,
  output logic [CW-1:0] hcounter,
  output logic [CW-1:0] vcounter,
  output logic          blank,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);

  logic          h_wrap;
  logic          v_wrap;
  logic [CW-1:0] h_nxt;
  logic [CW-1:0] v_nxt;
  logic          hs_nxt;
  logic          vs_nxt;
  logic          blank_nxt;

  always_comb begin
    h_wrap    = (hcounter == H_LAST);
    v_wrap    = h_wrap && (vcounter == V_LAST);
    h_nxt     = h_wrap ? '0 : hcounter + 1'b1;
    v_nxt     = vcounter;
    if (v_wrap) begin
      v_nxt = '0;
    end else if (h_wrap) begin
      v_nxt = vcounter + 1'b1;
    end
    // VS depends only on the line, so it stays asserted across whole sync lines.
    hs_nxt    = ((h_nxt >= HS_BEG) && (h_nxt < HS_END)) ? HS_POL : ~HS_POL;
    vs_nxt    = ((v_nxt >= VS_BEG) && (v_nxt < VS_END)) ? VS_POL : ~VS_POL;
    blank_nxt = (h_nxt >= H_ACT) || (v_nxt >= V_ACT);
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      hcounter    <= '0;
      vcounter    <= '0;
      HS          <= ~HS_POL;
      VS          <= ~VS_POL;
      blank       <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (en) begin
      hcounter    <= h_nxt;
      vcounter    <= v_nxt;
      HS          <= hs_nxt;
      VS          <= vs_nxt;
      blank       <= blank_nxt;
      line_start  <= h_wrap;
      frame_start <= v_wrap;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 Parameter H_FP, default 16, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, default 96, horizontal sync width in pixels.
REQ-004 Parameter H_BP, default 48, horizontal back porch in pixels.
REQ-005 Parameter V_ACTIVE, default 480, visible lines per frame.
REQ-006 Parameter V_FP, default 10, vertical front porch in lines.
REQ-007 Parameter V_SYNC, default 2, vertical sync width in lines.
REQ-008 Parameter V_BP, default 33, vertical back porch in lines.
REQ-009 Parameter HS_POL, default 0, active level of HS (0 = active-low).
REQ-010 Parameter VS_POL, default 0, active level of VS (0 = active-low).
REQ-011 Parameter CW, default 11, counter width; CW SHALL hold H_TOTAL-1 and V_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL is defined likewise.
REQ-012 One clock; reset is asynchronous and active-low.
REQ-013 pixel_clk  in  1  pixel clock; all state changes on its rising edge.
REQ-014 rst_n  in  1  asynchronous active-low reset.
REQ-015 en  in  1  count enable; low freezes all state and outputs.
REQ-016 HS  out  1  horizontal sync, polarity per HS_POL.
REQ-017 VS  out  1  vertical sync, polarity per VS_POL.
REQ-018 hcounter  out  CW  pixel position in the line, 0..H_TOTAL-1.
REQ-019 vcounter  out  CW  line position in the frame, 0..V_TOTAL-1.
REQ-020 blank  out  1  high outside the visible area.
REQ-021 line_start  out  1  one-cycle pulse when hcounter enters 0.
REQ-022 frame_start  out  1  one-cycle pulse when (hcounter,vcounter) enters (0,0).

Function
REQ-023 Every output SHALL be a register; HS, VS, blank and the pulses SHALL be aligned with the hcounter/vcounter values present in the same cycle (decoded from next-state values, zero cycles of skew).
REQ-024 Each line SHALL be ordered: active [0,H_ACTIVE), front porch, sync [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), back porch; vertical ordering is identical, in lines.
REQ-025 With en=1, hcounter SHALL increment by 1 per clock and wrap from H_TOTAL-1 to 0.
REQ-026 vcounter SHALL increment only on the cycle hcounter wraps, and SHALL wrap from V_TOTAL-1 to 0 on that same cycle.
REQ-027 HS SHALL equal HS_POL while hcounter is inside the horizontal sync window, and ~HS_POL otherwise.
REQ-028 VS SHALL equal VS_POL while vcounter is inside the vertical sync window, for all hcounter values of those lines, and ~VS_POL otherwise.
REQ-029 blank SHALL be 1 if and only if hcounter >= H_ACTIVE or vcounter >= V_ACTIVE.
REQ-030 line_start SHALL be 1 for exactly the one enabled cycle in which hcounter becomes 0 by wrap.
REQ-031 frame_start SHALL be 1 for exactly the one enabled cycle in which both counters become 0 by wrap; it coincides with line_start.
REQ-032 With en=0, counters and all outputs SHALL hold their values, except line_start and frame_start, which SHALL be 0.
REQ-033 When en rises again, counting SHALL resume from the held position with no skipped or repeated count.
REQ-034 Any porch or sync parameter equal to 1 SHALL produce a window exactly one pixel or one line wide; no window may be 0 (illegal configuration, not checked).

Reset
REQ-035 While rst_n=0, the block SHALL force hcounter=0, vcounter=0, HS=~HS_POL, VS=~VS_POL, blank=0, line_start=0 and frame_start=0, regardless of pixel_clk.
REQ-036 Reset asserted mid-line or mid-sync SHALL take effect immediately; the first clock after release with en=1 SHALL give hcounter=1, vcounter=0.
REQ-037 No frame_start or line_start pulse SHALL be produced by reset release itself.

Verification
REQ-038 Defaults, en=1, 2 full frames -> line period 800 clocks; frame period 420000 clocks; frame_start exactly once per 420000 clocks; line_start exactly 525 times per frame.
REQ-039 Defaults -> HS=0 exactly for hcounter 656..751; VS=0 exactly for vcounter 490..491; blank=1 exactly for hcounter>=640 or vcounter>=480.
REQ-040 H_ACTIVE=8, H_FP=H_SYNC=H_BP=1, V_ACTIVE=4, V_FP=V_SYNC=V_BP=1, HS_POL=VS_POL=1, CW=4 -> H_TOTAL=11; HS=1 only at hcounter=9; VS=1 only on vcounter=5; vcounter wraps at 6.
REQ-041 Defaults, en held low for 37 clocks at hcounter=799, vcounter=524 -> outputs frozen; the first enabled clock after release gives (0,0) with frame_start=1 and line_start=1.
REQ-042 rst_n pulsed low between clock edges at hcounter=700 -> immediate (0,0) with HS=1, VS=1, blank=0, and no pulse; counting restarts at 1.
REQ-043 Random en toggling over 3 frames -> a reference model of the counters and decodes matches every output on every cycle.
